// File: rtl/rob_regfile_commit.sv
`default_nettype none
// ============================================================================
// Module      : rob_regfile_commit
// Description : In-order commit stage of the RV32IM out-of-order core.
//               A circular reorder buffer (ROB) receives out-of-order
//               completions from the result buses and retires its head entry
//               in order into a 32x32 architectural register file. The
//               register file also tracks rename state (busy and ROB tag) and
//               serves two combinational lookup ports.
// Options     : COMMIT_TRACE_EN - when defined, each commit prints a
//               simulation trace line. Adds no hardware.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_regfile_commit #(
    parameter int ROB_DEPTH = 32,
    parameter int NUM_BUS   = 5,
    parameter int XLEN      = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    // result broadcast buses
    input  logic [NUM_BUS-1:0]                    bus_valid,
    input  logic [NUM_BUS-1:0][$clog2(ROB_DEPTH)-1:0] bus_dest_rob,
    input  logic [NUM_BUS-1:0][XLEN-1:0]          bus_value,
    // allocation
    input  logic                                  issue,
    input  logic [4:0]                            DR_entry_issue,
    // rename
    input  logic                                  iq_rf_write,
    input  logic [4:0]                            iq_rf_rd,
    input  logic [$clog2(ROB_DEPTH)-1:0]          iq_rf_rob_index,
    // source lookups
    input  logic [4:0]                            iq_rf_lookup_1,
    input  logic [4:0]                            iq_rf_lookup_2,
    output logic [XLEN-1:0]                       rf_value_1,
    output logic [XLEN-1:0]                       rf_value_2,
    output logic                                  rf_busy_1,
    output logic                                  rf_busy_2,
    output logic [$clog2(ROB_DEPTH)-1:0]          rf_tag_1,
    output logic [$clog2(ROB_DEPTH)-1:0]          rf_tag_2,
    // status
    output logic                                  cir_q_full,
    output logic                                  cir_q_empty,
    // commit port
    output logic                                  commit_valid,
    output logic [4:0]                            commit_rd,
    output logic [XLEN-1:0]                       commit_value,
    output logic [$clog2(ROB_DEPTH)-1:0]          commit_rob_index
);

    localparam int                 c_idx_w      = $clog2(ROB_DEPTH);
    localparam int                 c_num_regs   = 32;
    localparam logic [c_idx_w:0]   c_full_count = ROB_DEPTH[c_idx_w:0];

    // ROB storage
    logic [ROB_DEPTH-1:0]          r_valid;
    logic [ROB_DEPTH-1:0]          r_ready;
    logic [4:0]                    r_rd    [ROB_DEPTH];
    logic [XLEN-1:0]               r_value [ROB_DEPTH];
    logic [c_idx_w-1:0]            r_head;
    logic [c_idx_w-1:0]            r_tail;
    logic [c_idx_w:0]              r_count;

    // architectural register file with rename state
    logic [XLEN-1:0]               r_reg_value [c_num_regs];
    logic [c_num_regs-1:0]         r_reg_busy;
    logic [c_idx_w-1:0]            r_reg_tag   [c_num_regs];

    logic                          w_issue_ok;

    // status flags and commit port are direct decodes of current state
    always_comb begin
        cir_q_full       = (r_count == c_full_count);
        cir_q_empty      = (r_count == '0);
        w_issue_ok       = issue && !cir_q_full;
        commit_valid     = r_valid[r_head] && r_ready[r_head];
        commit_rd        = r_rd[r_head];
        commit_value     = r_value[r_head];
        commit_rob_index = r_head;
    end

    // ROB bookkeeping: completions, in-order retirement and allocation
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_ready[i] <= 1'b0;
                r_rd[i]    <= '0;
                r_value[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // ascending bus order lets the highest-numbered bus win a collision
            for (int b = 0; b < NUM_BUS; b++) begin
                if (bus_valid[b] && r_valid[bus_dest_rob[b]]) begin
                    r_ready[bus_dest_rob[b]] <= 1'b1;
                    r_value[bus_dest_rob[b]] <= bus_value[b];
                end
            end
            if (commit_valid) begin
                r_valid[r_head] <= 1'b0;
                r_ready[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            // the tail slot is always invalid when not full, so it never
            // collides with a completion or the retiring head
            if (w_issue_ok) begin
                r_valid[r_tail] <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_rd[r_tail]    <= DR_entry_issue;
                r_value[r_tail] <= '0;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_issue_ok, commit_valid})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // register file: commit writes the value, rename overrides busy/tag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < c_num_regs; r++) begin
                r_reg_value[r] <= '0;
                r_reg_tag[r]   <= '0;
            end
            r_reg_busy <= '0;
        end else begin
            if (commit_valid && (commit_rd != 5'd0)) begin
                r_reg_value[commit_rd] <= commit_value;
                // only the producer the register is still waiting on frees it
                if (r_reg_tag[commit_rd] == commit_rob_index) begin
                    r_reg_busy[commit_rd] <= 1'b0;
                end
            end
            // placed last so a same-cycle rename keeps the register busy
            if (iq_rf_write && (iq_rf_rd != 5'd0)) begin
                r_reg_busy[iq_rf_rd] <= 1'b1;
                r_reg_tag[iq_rf_rd]  <= iq_rf_rob_index;
            end
        end
    end

    // lookup ports read committed state only; x0 is hardwired to zero
    always_comb begin
        rf_value_1 = (iq_rf_lookup_1 == 5'd0) ? '0   : r_reg_value[iq_rf_lookup_1];
        rf_busy_1  = (iq_rf_lookup_1 == 5'd0) ? 1'b0 : r_reg_busy[iq_rf_lookup_1];
        rf_tag_1   = r_reg_tag[iq_rf_lookup_1];
        rf_value_2 = (iq_rf_lookup_2 == 5'd0) ? '0   : r_reg_value[iq_rf_lookup_2];
        rf_busy_2  = (iq_rf_lookup_2 == 5'd0) ? 1'b0 : r_reg_busy[iq_rf_lookup_2];
        rf_tag_2   = r_reg_tag[iq_rf_lookup_2];
    end

`ifdef COMMIT_TRACE_EN
    // simulation-only retirement trace
    always_ff @(posedge clk) begin
        if (!rst && commit_valid) begin
            $display("commit rob=%0d rd=%0d val=%h", commit_rob_index, commit_rd, commit_value);
        end
    end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob_regfile_commit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_regfile_commit
// Description : Self-checking bench for rob_regfile_commit. Issued entries
//               are queued as expected commits; a monitor pops and compares
//               every retirement seen on the commit port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_regfile_commit;

    logic             clk;
    logic             rst;
    logic [4:0]       bus_valid;
    logic [4:0][4:0]  bus_dest_rob;
    logic [4:0][31:0] bus_value;
    logic             issue;
    logic [4:0]       DR_entry_issue;
    logic             iq_rf_write;
    logic [4:0]       iq_rf_rd;
    logic [4:0]       iq_rf_rob_index;
    logic [4:0]       iq_rf_lookup_1;
    logic [4:0]       iq_rf_lookup_2;
    logic [31:0]      rf_value_1;
    logic [31:0]      rf_value_2;
    logic             rf_busy_1;
    logic             rf_busy_2;
    logic [4:0]       rf_tag_1;
    logic [4:0]       rf_tag_2;
    logic             cir_q_full;
    logic             cir_q_empty;
    logic             commit_valid;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_value;
    logic [4:0]       commit_rob_index;

    rob_regfile_commit #(.ROB_DEPTH(32), .NUM_BUS(5), .XLEN(32)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .bus_valid        (bus_valid),
        .bus_dest_rob     (bus_dest_rob),
        .bus_value        (bus_value),
        .issue            (issue),
        .DR_entry_issue   (DR_entry_issue),
        .iq_rf_write      (iq_rf_write),
        .iq_rf_rd         (iq_rf_rd),
        .iq_rf_rob_index  (iq_rf_rob_index),
        .iq_rf_lookup_1   (iq_rf_lookup_1),
        .iq_rf_lookup_2   (iq_rf_lookup_2),
        .rf_value_1       (rf_value_1),
        .rf_value_2       (rf_value_2),
        .rf_busy_1        (rf_busy_1),
        .rf_busy_2        (rf_busy_2),
        .rf_tag_1         (rf_tag_1),
        .rf_tag_2         (rf_tag_2),
        .cir_q_full       (cir_q_full),
        .cir_q_empty      (cir_q_empty),
        .commit_valid     (commit_valid),
        .commit_rd        (commit_rd),
        .commit_value     (commit_value),
        .commit_rob_index (commit_rob_index)
    );

    typedef struct {
        logic [4:0] rob;
        logic [4:0] rd;
    } exp_t;

    exp_t        r_sb_q[$];
    logic [31:0] r_exp_val [32];
    int          r_checks;
    int          r_errors;
    int          r_commits;
    logic        r_mon_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard monitor: every retirement must match the oldest issued entry
    always @(negedge clk) begin
        if (r_mon_en && commit_valid) begin
            r_commits++;
            if (r_sb_q.size() == 0) begin
                check("unexpected_commit", 32'(commit_rob_index), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = r_sb_q.pop_front();
                check("commit_rob", 32'(commit_rob_index), 32'(e.rob));
                check("commit_rd", 32'(commit_rd), 32'(e.rd));
                check("commit_value", commit_value, r_exp_val[e.rob]);
            end
        end
    end

    task automatic idle_inputs();
        bus_valid       = '0;
        bus_dest_rob    = '0;
        bus_value       = '0;
        issue           = 1'b0;
        DR_entry_issue  = '0;
        iq_rf_write     = 1'b0;
        iq_rf_rd        = '0;
        iq_rf_rob_index = '0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            idle_inputs();
        end
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic ren, input logic [4:0] rrd,
                            input logic [4:0] ridx, input logic expect_accept);
        exp_t e;
        issue           = 1'b1;
        DR_entry_issue  = rd;
        iq_rf_write     = ren;
        iq_rf_rd        = rrd;
        iq_rf_rob_index = ridx;
        if (expect_accept) begin
            e.rob = ridx;
            e.rd  = rd;
            r_sb_q.push_back(e);
        end
        tick(1);
    endtask

    task automatic drive_bus(input int b, input logic [4:0] rob, input logic [31:0] val);
        bus_valid[b]    = 1'b1;
        bus_dest_rob[b] = rob;
        bus_value[b]    = val;
        r_exp_val[rob]  = val;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] val,
                           input logic busy, input logic [4:0] tg);
        iq_rf_lookup_1 = r;
        iq_rf_lookup_2 = r;
        #1;
        check({tag, "_val1"}, rf_value_1, val);
        check({tag, "_busy1"}, 32'(rf_busy_1), 32'(busy));
        check({tag, "_tag1"}, 32'(rf_tag_1), 32'(tg));
        check({tag, "_val2"}, rf_value_2, val);
        check({tag, "_busy2"}, 32'(rf_busy_2), 32'(busy));
    endtask

    int c0;

    initial begin
        r_checks  = 0;
        r_errors  = 0;
        r_commits = 0;
        r_mon_en  = 1'b0;
        for (int i = 0; i < 32; i++) r_exp_val[i] = '0;
        iq_rf_lookup_1 = '0;
        iq_rf_lookup_2 = '0;
        idle_inputs();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst      = 1'b0;
        r_mon_en = 1'b1;

        // reset state
        check("rst_empty", 32'(cir_q_empty), 32'd1);
        check("rst_full", 32'(cir_q_full), 32'd0);
        check("rst_commit_valid", 32'(commit_valid), 32'd0);
        chk_reg("rst_r5", 5'd5, 32'd0, 1'b0, 5'd0);
        chk_reg("rst_r31", 5'd31, 32'd0, 1'b0, 5'd0);

        // fill all 32 entries, renaming rd=i to tag i
        for (int i = 0; i < 32; i++) begin
            do_issue(5'(i), 1'b1, 5'(i), 5'(i), 1'b1);
        end
        check("fill_full", 32'(cir_q_full), 32'd1);
        check("fill_empty", 32'(cir_q_empty), 32'd0);
        // issue while full must be dropped
        do_issue(5'd9, 1'b0, 5'd0, 5'd0, 1'b0);
        check("over_full", 32'(cir_q_full), 32'd1);
        chk_reg("fill_r3", 5'd3, 32'd0, 1'b1, 5'd3);
        chk_reg("fill_r0", 5'd0, 32'd0, 1'b0, 5'd0);

        // in-order drain of rob 0..4
        c0 = r_commits;
        for (int k = 0; k < 5; k++) begin
            drive_bus(0, 5'(k), 32'(200 + k));
            tick(1);
        end
        tick(2);
        check("drain_commits", 32'(r_commits - c0), 32'd5);
        check("drain_not_full", 32'(cir_q_full), 32'd0);
        chk_reg("drain_r1", 5'd1, 32'd201, 1'b0, 5'd1);
        chk_reg("drain_r4", 5'd4, 32'd204, 1'b0, 5'd4);
        chk_reg("drain_r0", 5'd0, 32'd0, 1'b0, 5'd0);

        // wrap-around: rd 20..24 into rob 0..4
        for (int j = 0; j < 5; j++) begin
            do_issue(5'(20 + j), 1'b1, 5'(20 + j), 5'(j), 1'b1);
        end
        check("wrap_full", 32'(cir_q_full), 32'd1);
        chk_reg("wrap_r20", 5'd20, 32'd0, 1'b1, 5'd0);

        // out-of-order completion: only rob 5 can retire
        c0 = r_commits;
        drive_bus(0, 5'd8, 32'd508);
        drive_bus(1, 5'd14, 32'd514);
        drive_bus(2, 5'd7, 32'd507);
        drive_bus(3, 5'd12, 32'd512);
        drive_bus(4, 5'd5, 32'd505);
        tick(1);
        tick(3);
        check("ooo_stall_commits", 32'(r_commits - c0), 32'd1);
        check("ooo_stall_valid", 32'(commit_valid), 32'd0);
        c0 = r_commits;
        drive_bus(0, 5'd6, 32'd506);
        drive_bus(1, 5'd9, 32'd509);
        drive_bus(2, 5'd11, 32'd511);
        drive_bus(3, 5'd13, 32'd513);
        drive_bus(4, 5'd10, 32'd510);
        tick(1);
        tick(12);
        check("ooo_release_commits", 32'(r_commits - c0), 32'd9);
        chk_reg("ooo_r7", 5'd7, 32'd507, 1'b0, 5'd7);
        chk_reg("ooo_r14", 5'd14, 32'd514, 1'b0, 5'd14);

        // stale tags: r20..r24 now wait on rob 0..4
        c0 = r_commits;
        for (int base = 15; base < 32; base += 5) begin
            for (int b = 0; b < 5; b++) begin
                if (base + b < 32) drive_bus(b, 5'(base + b), 32'(500 + base + b));
            end
            tick(1);
        end
        tick(20);
        check("stale_commits", 32'(r_commits - c0), 32'd17);
        chk_reg("stale_r20", 5'd20, 32'd520, 1'b1, 5'd0);
        chk_reg("stale_r31", 5'd31, 32'd531, 1'b0, 5'd31);

        // final drain
        c0 = r_commits;
        for (int b = 0; b < 5; b++) drive_bus(b, 5'(b), 32'(220 + b));
        tick(1);
        tick(6);
        check("final_commits", 32'(r_commits - c0), 32'd5);
        check("final_empty", 32'(cir_q_empty), 32'd1);
        chk_reg("final_r20", 5'd20, 32'd220, 1'b0, 5'd0);
        chk_reg("final_r24", 5'd24, 32'd224, 1'b0, 5'd4);

        // broadcast to an invalid entry is ignored
        c0 = r_commits;
        drive_bus(2, 5'd20, 32'hDEAD);
        tick(1);
        tick(2);
        check("invalid_bcast_commits", 32'(r_commits - c0), 32'd0);
        check("invalid_bcast_empty", 32'(cir_q_empty), 32'd1);

        // bus priority plus rename colliding with commit on the same register
        do_issue(5'd3, 1'b0, 5'd0, 5'd5, 1'b1);
        bus_valid[0] = 1'b1; bus_dest_rob[0] = 5'd5; bus_value[0] = 32'd111;
        drive_bus(3, 5'd5, 32'd333);
        tick(1);
        check("prio_commit_valid", 32'(commit_valid), 32'd1);
        iq_rf_write     = 1'b1;
        iq_rf_rd        = 5'd3;
        iq_rf_rob_index = 5'd9;
        tick(1);
        tick(1);
        chk_reg("collide_r3", 5'd3, 32'd333, 1'b1, 5'd9);
        check("end_empty", 32'(cir_q_empty), 32'd1);
        check("sb_leftover", 32'(r_sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
        $finish;
    end

    // hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
